// File: rtl/coin_intake.sv
// Coin sensor front end: two-flop sync, per-channel debounce, rising-edge coin events,
// and a small ordered queue that feeds single-cycle nickel/dime credit pulses.
module coin_intake #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int QUEUE_DEPTH     = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           nickel_raw,
    input  logic                           dime_raw,
    input  logic                           accept_en,
    output logic                           nickel_in,
    output logic                           dime_in,
    output logic                           coin_reject,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           queue_full
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = CW + 1;
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 is the nickel, 1 is the dime.
    logic [1:0] raw;
    logic [1:0] sync_p0;
    logic [1:0] sync_p1;
    logic [1:0] level;
    logic [7:0] cnt [2];
    logic [1:0] ev;

    assign raw = {dime_raw, nickel_raw};

    // Stage p0/p1: synchroniser, then debounce against the accepted level
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            level   <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    level[i] <= sync_p1[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    // An event is flagged in the cycle the level is about to rise, so the push lands on that same edge.
    always_comb begin
        ev = '0;
        for (int i = 0; i < 2; i++)
            ev[i] = ~level[i] & sync_p1[i] & (cnt[i] == DB_LAST);
    end

    logic [QUEUE_DEPTH-1:0] mem;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic                   pop;
    logic [FW-1:0]          free_slots;
    logic                   push_n;
    logic                   push_d;
    logic                   reject;
    logic [CW-1:0]          count_next;

    always_comb begin
        pop        = accept_en && (queue_count != '0);
        free_slots = FW'(QUEUE_DEPTH) - {1'b0, queue_count} + FW'(pop);
        push_n     = ev[0] && (free_slots != '0);
        push_d     = ev[1] && (free_slots > (push_n ? FW'(1) : FW'(0)));
        reject     = (ev[0] && !push_n) || (ev[1] && !push_d);
        count_next = queue_count + CW'(push_n) + CW'(push_d) - CW'(pop);
    end

    // Stage p2: queue pointers, occupancy and registered credit/reject pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_count <= '0;
            nickel_in   <= 1'b0;
            dime_in     <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            rd_ptr      <= rd_ptr + PW'(pop);
            wr_ptr      <= wr_ptr + PW'(push_n) + PW'(push_d);
            queue_count <= count_next;
            nickel_in   <= pop & ~mem[rd_ptr];
            dime_in     <= pop & mem[rd_ptr];
            coin_reject <= reject;
        end
    end

    // Coin-type storage is data only; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (push_n) mem[wr_ptr] <= 1'b0;
        if (push_d) mem[wr_ptr + PW'(push_n)] <= 1'b1;
    end

    assign queue_full = (queue_count == CW'(QUEUE_DEPTH));

endmodule

// File: tb/tb_coin_intake.sv
// Directed bench for coin_intake: per-cycle vector table for single-coin timing and
// glitch rejection, plus hand-written sequences for queueing, overflow and reset.
module tb_coin_intake;

    logic       clock = 1'b0;
    logic       reset;
    logic       nickel_raw;
    logic       dime_raw;
    logic       accept_en;
    logic       nickel_in;
    logic       dime_in;
    logic       coin_reject;
    logic [2:0] queue_count;
    logic       queue_full;

    coin_intake #(.DEBOUNCE_CYCLES(4), .QUEUE_DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .nickel_raw  (nickel_raw),
        .dime_raw    (dime_raw),
        .accept_en   (accept_en),
        .nickel_in   (nickel_in),
        .dime_in     (dime_in),
        .coin_reject (coin_reject),
        .queue_count (queue_count),
        .queue_full  (queue_full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic n;
        logic d;
        logic a;
        logic ni;
        logic di;
        logic rj;
        int   qc;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   rej_cnt  = 0;
    int   both_cnt = 0;
    int   rej0;
    bit   plog[$];

    // Pulse log in output order: 0 = nickel_in, 1 = dime_in.
    always @(negedge clock) begin
        if (nickel_in === 1'b1 && dime_in === 1'b1) both_cnt++;
        else if (nickel_in === 1'b1) plog.push_back(1'b0);
        else if (dime_in === 1'b1) plog.push_back(1'b1);
        if (coin_reject === 1'b1) rej_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic row(input logic n, input logic d, input logic a,
                       input logic ni, input logic di, input logic rj, input int qc);
        vec_t v;
        v.n = n; v.d = d; v.a = a; v.ni = ni; v.di = di; v.rj = rj; v.qc = qc;
        tbl.push_back(v);
    endtask

    task automatic hold(input logic n, input logic d, input int cycles);
        nickel_raw = n;
        dime_raw   = d;
        repeat (cycles) tick();
    endtask

    task automatic coin(input logic n, input logic d);
        hold(n, d, 6);
        hold(1'b0, 1'b0, 8);
    endtask

    task automatic chk_log(input string nm, input int len, input logic [7:0] pattern);
        chk({nm, "_len"}, plog.size(), len);
        for (int i = 0; i < len; i++)
            if (i < plog.size()) chk($sformatf("%s_%0d", nm, i), 32'(plog[i]), 32'(pattern[i]));
    endtask

    initial begin
        nickel_raw = 1'b0;
        dime_raw   = 1'b0;
        accept_en  = 1'b0;
        reset      = 1'b1;
        tick();
        tick();
        chk("rst_nickel_in", nickel_in, 0);
        chk("rst_dime_in", dime_in, 0);
        chk("rst_reject", coin_reject, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_full", queue_full, 0);
        reset = 1'b0;

        // Clean nickel held 10 cycles: push after the 6th edge, credit after the 7th.
        for (int i = 0; i < 5; i++) row(1, 0, 1, 0, 0, 0, 0);
        row(1, 0, 1, 0, 0, 0, 1);
        row(1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) row(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) row(0, 0, 1, 0, 0, 0, 0);
        // 3-cycle dime glitch: counter peaks one short of acceptance.
        for (int i = 0; i < 3; i++) row(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) row(0, 0, 1, 0, 0, 0, 0);
        // 6-cycle dime pulse: exactly one credit.
        for (int i = 0; i < 5; i++) row(0, 1, 1, 0, 0, 0, 0);
        row(0, 1, 1, 0, 0, 0, 1);
        row(0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) row(0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            nickel_raw = tbl[i].n;
            dime_raw   = tbl[i].d;
            accept_en  = tbl[i].a;
            tick();
            chk($sformatf("vec%0d_nickel_in", i), nickel_in, tbl[i].ni);
            chk($sformatf("vec%0d_dime_in", i), dime_in, tbl[i].di);
            chk($sformatf("vec%0d_reject", i), coin_reject, tbl[i].rj);
            chk($sformatf("vec%0d_count", i), queue_count, tbl[i].qc);
            chk($sformatf("vec%0d_full", i), queue_full, 32'(tbl[i].qc == 4));
        end
        chk_log("vec_order", 2, 8'b0000_0010);

        // Queue three coins while blocked, then drain on consecutive cycles.
        accept_en = 1'b0;
        plog.delete();
        coin(1, 0);
        coin(0, 1);
        coin(1, 0);
        chk("q3_count", queue_count, 3);
        accept_en = 1'b1;
        tick();
        chk("q3_pop1_ni", nickel_in, 1); chk("q3_pop1_di", dime_in, 0); chk("q3_pop1_cnt", queue_count, 2);
        tick();
        chk("q3_pop2_ni", nickel_in, 0); chk("q3_pop2_di", dime_in, 1); chk("q3_pop2_cnt", queue_count, 1);
        tick();
        chk("q3_pop3_ni", nickel_in, 1); chk("q3_pop3_di", dime_in, 0); chk("q3_pop3_cnt", queue_count, 0);
        tick();
        chk("q3_idle_ni", nickel_in, 0); chk("q3_idle_di", dime_in, 0);

        // Fill the queue, then a fifth dime overflows.
        accept_en = 1'b0;
        coin(1, 0);
        coin(0, 1);
        coin(1, 0);
        coin(0, 1);
        chk("full_count", queue_count, 4);
        chk("full_flag", queue_full, 1);
        rej0 = rej_cnt;
        hold(0, 1, 6);
        chk("ovf_reject", coin_reject, 1);
        chk("ovf_count", queue_count, 4);
        tick();
        chk("ovf_reject_end", coin_reject, 0);
        hold(0, 0, 8);
        chk("ovf_reject_pulses", rej_cnt - rej0, 1);
        plog.delete();
        accept_en = 1'b1;
        repeat (6) tick();
        chk_log("ovf_drain", 4, 8'b0000_1010);
        chk("ovf_drained_count", queue_count, 0);

        // One free slot, simultaneous events: nickel kept, dime rejected.
        accept_en = 1'b0;
        plog.delete();
        coin(1, 0);
        coin(0, 1);
        coin(1, 0);
        chk("dual_pre_count", queue_count, 3);
        rej0 = rej_cnt;
        hold(1, 1, 6);
        chk("dual_reject", coin_reject, 1);
        chk("dual_count", queue_count, 4);
        tick();
        chk("dual_reject_end", coin_reject, 0);
        hold(0, 0, 8);
        chk("dual_reject_pulses", rej_cnt - rej0, 1);
        accept_en = 1'b1;
        repeat (6) tick();
        chk_log("dual_drain", 4, 8'b0000_0010);

        // Same again but with a pop on the event cycle: both fit.
        accept_en = 1'b0;
        coin(1, 0);
        coin(0, 1);
        coin(1, 0);
        chk("dualpop_pre_count", queue_count, 3);
        plog.delete();
        rej0 = rej_cnt;
        hold(1, 1, 5);
        accept_en = 1'b1;
        tick();
        chk("dualpop_ni", nickel_in, 1);
        chk("dualpop_count", queue_count, 4);
        chk("dualpop_reject", coin_reject, 0);
        accept_en = 1'b0;
        tick();
        chk("dualpop_hold_count", queue_count, 4);
        chk("dualpop_hold_ni", nickel_in, 0);
        hold(0, 0, 8);
        // Full queue, both events rejected together: a single reject pulse.
        hold(1, 1, 6);
        chk("both_rej_reject", coin_reject, 1);
        chk("both_rej_count", queue_count, 4);
        tick();
        chk("both_rej_reject_end", coin_reject, 0);
        hold(0, 0, 8);
        chk("both_rej_pulses", rej_cnt - rej0, 1);
        accept_en = 1'b1;
        repeat (6) tick();
        chk_log("dualpop_order", 5, 8'b0001_0010);

        // Reset with two queued coins and a nickel mid-debounce.
        accept_en = 1'b0;
        coin(1, 0);
        coin(0, 1);
        chk("rstmid_pre_count", queue_count, 2);
        hold(1, 0, 3);
        reset = 1'b1;
        rej0  = rej_cnt;
        tick();
        chk("rstmid_ni", nickel_in, 0);
        chk("rstmid_di", dime_in, 0);
        chk("rstmid_reject", coin_reject, 0);
        chk("rstmid_count", queue_count, 0);
        chk("rstmid_full", queue_full, 0);
        reset     = 1'b0;
        accept_en = 1'b1;
        plog.delete();
        repeat (5) tick();
        chk("rstmid_held_count5", queue_count, 0);
        tick();
        chk("rstmid_held_count6", queue_count, 1);
        tick();
        chk("rstmid_held_ni", nickel_in, 1);
        chk("rstmid_held_count7", queue_count, 0);
        hold(0, 0, 10);
        chk_log("rstmid_pulses", 1, 8'b0000_0000);
        chk("rstmid_rejects", rej_cnt - rej0, 0);

        chk("never_both_high", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
